// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - client/divider handshake bundle for seq_divider
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             ready;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, ready, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, ready, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - shared iterative unsigned restoring divider, one quotient bit per clock
// Optional round-half-up quotient stage enabled by defining DIVIDER_ROUND_EN.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic        clk,
  input logic        rst,
  seq_divider_if.slave bus
);

`ifdef DIVIDER_ROUND_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ROUND} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_shift_r;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  // One restoring step: shift {R,Q} left, subtract D when it fits.
  assign w_shift_r = (r_rem << 1) | {{WIDTH{1'b0}}, r_q[WIDTH-1]};
  assign w_ge      = (w_shift_r >= {1'b0, r_d});
  assign w_sub     = w_shift_r - {1'b0, r_d};
  assign w_r_next  = w_ge ? w_sub : w_shift_r;
  assign w_q_next  = {r_q[WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIVIDER_ROUND_EN
  logic             w_round_up;
  logic [WIDTH-1:0] w_q_rounded;

  // Saturate instead of wrapping; a zero divisor keeps the all-ones marker.
  assign w_round_up  = ({r_rem, 1'b0} >= {2'b00, r_d}) && (r_q != '1) && !r_dz;
  assign w_q_rounded = r_q + WIDTH'(w_round_up);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
`ifdef DIVIDER_ROUND_EN
          w_next_state = S_ROUND;
`else
          w_next_state = S_DONE;
`endif
        end
      end
`ifdef DIVIDER_ROUND_EN
      S_ROUND: w_next_state = S_DONE;
`endif
      S_DONE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q           <= '0;
      r_d           <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_q   <= bus.dividend;
      r_d   <= bus.divisor;
      r_rem <= '0;
      r_cnt <= '0;
      r_dz  <= (bus.divisor == '0);
    end else if (r_state == S_RUN) begin
      r_q   <= w_q_next;
      r_rem <= w_r_next;
      r_cnt <= r_cnt + 1'b1;
`ifndef DIVIDER_ROUND_EN
      // The final RUN edge is also the DONE entry edge, so publish the step result directly.
      if (w_last) begin
        r_quotient    <= w_q_next;
        r_remainder   <= w_r_next[WIDTH-1:0];
        r_div_by_zero <= r_dz;
      end
`endif
    end
`ifdef DIVIDER_ROUND_EN
    else if (r_state == S_ROUND) begin
      r_quotient    <= w_q_rounded;
      r_remainder   <= r_rem[WIDTH-1:0];
      r_div_by_zero <= r_dz;
    end
`endif
  end

`ifdef DIVIDER_ROUND_EN
  assign bus.busy = (r_state == S_RUN) || (r_state == S_ROUND);
`else
  assign bus.busy = (r_state == S_RUN);
`endif
  assign bus.ready       = (r_state == S_DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference
module tb_seq_divider;
  localparam int WIDTH = 16;
`ifdef DIVIDER_ROUND_EN
  localparam int LAT = WIDTH + 1;
`else
  localparam int LAT = WIDTH;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_q(input int a, input int b);
    int q;
    int r;
    if (b == 0) return 16'hFFFF;
    q = a / b;
    r = a % b;
`ifdef DIVIDER_ROUND_EN
    if (2 * r >= b && q != 65535) q = q + 1;
`endif
    return q[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] model_r(input int a, input int b);
    int r;
    r = (b == 0) ? a : a % b;
    return r[WIDTH-1:0];
  endfunction

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_rise", bus.busy, 1);
  endtask

  // Waits for ready after a launch; optionally scrambles operands or pokes start mid-run.
  task automatic wait_result(input int a, input int b, input bit scramble, input int poke);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      if (scramble) begin
        bus.dividend = WIDTH'($urandom);
        bus.divisor  = WIDTH'($urandom);
      end
      if (n == poke) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (bus.ready) got = 1'b1;
    end
    bus.start = 1'b0;
    check("latency", n, LAT);
    check("busy_done", bus.busy, 0);
    check("quotient", bus.quotient, model_q(a, b));
    check("remainder", bus.remainder, model_r(a, b));
    check("div_by_zero", bus.div_by_zero, (b == 0));
  endtask

  task automatic run_div(input int a, input int b);
    launch(a[WIDTH-1:0], b[WIDTH-1:0]);
    wait_result(a, b, 1'b0, -1);
    @(negedge clk);
    check("ready_pulse_end", bus.ready, 0);
  endtask

  initial begin
    int pulses;
    int ra;
    int rb;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", bus.busy, 0);
    check("reset_ready", bus.ready, 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_dz", bus.div_by_zero, 0);

    run_div(36000, 11);
    run_div(65535, 1);
    run_div(999, 1000);
    run_div(5, 0);
    run_div(100, 7);

    // Start pulsed mid-run is ignored, then a start in the DONE cycle is taken back-to-back.
    launch(16'd36000, 16'd11);
    wait_result(36000, 11, 1'b0, 5);
    launch(16'd1000, 16'd3);
    wait_result(1000, 3, 1'b0, -1);
    @(negedge clk);
    check("b2b_ready_end", bus.ready, 0);

    // Reset on the 8th RUN edge aborts the division without a ready pulse.
    launch(16'd36000, 16'd11);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_ready", bus.ready, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_dz", bus.div_by_zero, 0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    check("abort_no_ready", pulses, 0);

    bus.start    = 1'b1;
    bus.dividend = 16'd50;
    bus.divisor  = 16'd5;
    rst          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("start_rst_idle", bus.busy, 0);

    // Operands scrambled throughout RUN must not disturb the latched values.
    launch(16'd1234, 16'd10);
    wait_result(1234, 10, 1'b1, -1);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    check("single_ready", pulses, 0);
    check("hold_quotient", bus.quotient, model_q(1234, 10));
    check("hold_remainder", bus.remainder, 4);

    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom_range(0, 65535));
      case (i % 4)
        0:       rb = 0;
        1:       rb = int'($urandom_range(1, 15));
        default: rb = int'($urandom_range(1, 65535));
      endcase
      run_div(ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Shared iterative unsigned restoring divider for the bike computer. It serves the average-speed stage and any other client routed to it by the top-level arbiter.
- Takes a dividend/divisor pair on a start strobe and produces one quotient bit per clock.
- Reports progress on busy/ready. Clients present operands while busy=0, wait for busy=1, then wait for ready=1 and take quotient.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- dividend  in  WIDTH  unsigned numerator, latched on accepted start.
- divisor  in  WIDTH  unsigned denominator, latched on accepted start.
- quotient  out  WIDTH  result; holds until next completion.
- remainder  out  WIDTH  dividend mod divisor; holds with quotient.
- busy  out  1  high while a division is in progress.
- ready  out  1  single-cycle completion pulse.
- div_by_zero  out  1  high with result when latched divisor was 0; holds with quotient.

Behaviour:
- Reset (rst=1, synchronous, wins over start): state IDLE; quotient=0, remainder=0, busy=0, ready=0, div_by_zero=0; internal registers and counter cleared.
- States: IDLE, RUN, DONE, plus ROUND when the option is enabled.
- Start acceptance: start=1 in IDLE or DONE.
  - Latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits) and counter.
  - Record dz = (divisor==0).
  - Go to RUN; busy=1 from the next cycle.
- start while busy=1: ignored, no queuing.
- RUN, each edge:
  - {R,Q} <= {R,Q} << 1.
  - If shifted R >= D: R <= shifted R - D, Q[0] <= 1; else Q[0] <= 0.
  - Counter increments.
  - After the WIDTH-th RUN edge, go to DONE (or ROUND).
- Subtraction is performed at WIDTH+1 bits; no overflow is possible for D != 0.
- DONE entry edge:
  - quotient <= Q, remainder <= R[WIDTH-1:0], div_by_zero <= dz.
  - busy <= 0, ready <= 1.
- DONE, next edge: ready <= 0. Go to IDLE, or to RUN if start=1 that cycle (back-to-back accepted).
- Latency: with start sampled at edge E0, busy=1 after E0..E(WIDTH-1), ready=1 and results valid after E(WIDTH). That is 16 cycles at default, 17 with rounding.
- Divide by zero: full latency is preserved; quotient = all ones (0xFFFF), remainder = latched dividend, div_by_zero=1.
- Operand inputs may change freely after acceptance; the result depends only on the latched values.
- Outputs quotient, remainder and div_by_zero change only on a DONE entry edge or on reset.
- Reset mid-RUN: aborts, all outputs return to reset values, no ready pulse.
- IDLE with start=0: no change; quotient/remainder keep the last result.

Optional Feature:
- Macro: DIVIDER_ROUND_EN.
- Defined:
  - ROUND state inserted between RUN and DONE (+1 cycle latency, busy held high).
  - quotient <= Q+1 when 2*R >= D, Q != all ones and dz=0; otherwise quotient = Q (saturates, no wrap).
  - remainder output remains the raw truncated remainder.
- Undefined:
  - No ROUND state; quotient is truncated (floor).
  - Latency exactly WIDTH edges.

Test Plan:
- 36000/11 -> busy rises the cycle after start; ready pulse once after 16 edges; quotient=3272, remainder=8, div_by_zero=0. With DIVIDER_ROUND_EN: quotient=3273 after 17 edges.
- 65535/1 -> quotient=65535, remainder=0. 999/1000 -> quotient=0, remainder=999; with rounding quotient=1.
- 5/0 -> quotient=0xFFFF, remainder=5, div_by_zero=1 after full latency. Next division 100/7 -> quotient=14, remainder=2, div_by_zero=0.
- start pulsed again mid-RUN with 1000/3 on inputs -> ignored; first operands 36000/11 complete with quotient=3272. Then start in the DONE cycle with 1000/3 -> accepted, quotient=333, remainder=1.
- rst asserted on the 8th RUN edge of 36000/11 -> next cycle busy=0, ready=0, quotient=0, remainder=0; no ready pulse follows. start+rst in the same cycle -> stays IDLE.
- Operands changed every cycle during RUN of 1234/10 -> result still quotient=123, remainder=4. ready high exactly one cycle; quotient stable for 20 idle cycles afterwards.
